epp_host: RTL and testbench
===========================

EPP_HOST -- requirements
Module: epp_host

Interface
REQ-001 SHALL have parameter SETUP, default 2, strobe-setup cycles with nWrite/data stable before strobe falls.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waiting on any nWait edge (8-bit counter).
REQ-003 SHALL have parameter RST_CYCLES, default 64, nInit low time for a bus reset.
REQ-004 Port: clk  input  1  single clock; all logic on posedge clk.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: req_valid  input  1  request present.
REQ-007 Port: req_ready  output  1  request accepted when valid & ready.
REQ-008 Port: req_op  input  2  00 data write, 01 data read, 10 address write, 11 bus reset.
REQ-009 Port: req_data  input  8  write byte.
REQ-010 Port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 Port: resp_data  output  8  read byte (0 for writes/errors).
REQ-012 Port: resp_timeout  output  1  qualifies resp_valid: cycle aborted.
REQ-013 Port: pd_out  output  8  byte driven onto pport_data.
REQ-014 Port: pd_oe  output  1  pport_data drive enable.
REQ-015 Port: pd_in  input  8  pport_data as seen on pins.
REQ-016 Port: nWrite, nAddrStr, nDataStr, nInit  output  1 each  EPP host controls, active low.
REQ-017 Port: nWait  input  1  peripheral handshake, asynchronous; low = acknowledge.

Function
REQ-018 nWait SHALL pass a 2-flop synchronizer; all handshake decisions use the synchronized value (ws).
REQ-019 States SHALL be IDLE, SETUP, STROBE, RELEASE, BUSRST.
REQ-020 IDLE: req_ready=1; on accept latch op/data, clear timer, go SETUP (ops 00-10) or BUSRST (op 11); req_ready=0 in all other states.
REQ-021 SETUP: nWrite=0 and pd_oe=1 with pd_out=latched byte for writes; nWrite=1, pd_oe=0 for reads; after exactly SETUP cycles go STROBE.
REQ-022 STROBE: assert nAddrStr (op 10) or nDataStr (ops 00/01), never both; on ws=0 capture pd_in (reads) and go RELEASE.
REQ-023 RELEASE: strobes deasserted, nWrite/pd_oe held as in SETUP; on ws=1 go IDLE, pulse resp_valid with resp_timeout=0.
REQ-024 Timer SHALL count cycles in STROBE and RELEASE separately; reaching TIMEOUT deasserts strobes, drops pd_oe, nWrite=1, pulses resp_valid with resp_timeout=1, resp_data=0, returns IDLE.
REQ-025 BUSRST: nInit=0 for RST_CYCLES cycles, all other controls idle, then resp_valid pulse, return IDLE.
REQ-026 ws already low on STROBE entry SHALL count as immediate acknowledge (no edge requirement).
REQ-027 pd_oe SHALL never be 1 while nWrite=1.
REQ-028 resp_data SHALL hold last value until next resp_valid.

Reset
REQ-029 While reset: state IDLE, req_ready=0, resp_valid=0, resp_data=0, resp_timeout=0, pd_oe=0, pd_out=0, nWrite=nAddrStr=nDataStr=nInit=1, synchronizer flops=1.
REQ-030 Reset mid-cycle SHALL abort with no resp_valid; req_ready=1 from first clock after release.

Structure
REQ-031 Package epp_host_pkg SHALL hold op-code constants and the state enum.
REQ-032 Synchronizer SHALL be sub-module epp_sync2 (2-flop, reset value 1); FSM and timer in epp_host.

Verification
REQ-033 Data write 0xA5, model acks 3 cycles after nDataStr falls, releases 2 cycles after strobe rises -> pd_out=0xA5, nWrite=0 from SETUP through RELEASE, one resp_valid, resp_timeout=0.
REQ-034 Data read, model drives 0x3C while acking -> resp_data=0x3C, pd_oe=0 throughout, nWrite=1.
REQ-035 Address write 0x09 then data write 0x41 back-to-back -> nAddrStr then nDataStr strobed, never overlapping, two resp_valid pulses.
REQ-036 Model never acks -> strobe drops after 255 STROBE cycles, resp_valid with resp_timeout=1, resp_data=0, next request accepted.
REQ-037 Bus reset op -> nInit low exactly 64 cycles, resp_valid once; reset asserted during STROBE -> all controls idle immediately, no resp_valid.

Source files
------------

// File: rtl/epp_host_pkg.sv
// Shared definitions for the EPP host controller.
//   op codes : request operation encoding on req_op
//   state_t  : controller state encoding
package epp_host_pkg;

  localparam logic [1:0] OP_DWR  = 2'b00;  // data write
  localparam logic [1:0] OP_DRD  = 2'b01;  // data read
  localparam logic [1:0] OP_AWR  = 2'b10;  // address write
  localparam logic [1:0] OP_BRST = 2'b11;  // bus reset (nInit pulse)

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_BUSRST
  } state_t;

  // True for ops that drive pport_data (address and data writes).
  function automatic logic op_drives_bus(input logic [1:0] op);
    return (op == OP_DWR) || (op == OP_AWR);
  endfunction

endpackage

// File: rtl/epp_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk   : sampling clock
//   reset : asynchronous active-high reset, both flops reset to 1
//   d     : asynchronous input
//   q     : synchronized output
module epp_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/epp_host.sv
// EPP host: turns single-byte requests into EPP address/data cycles with
// a strobe-setup phase, nWait handshake with timeout, and a bus reset op.
//   clk, reset               : clock, asynchronous active-high reset
//   req_valid/ready/op/data  : request handshake
//   resp_valid/data/timeout  : one-cycle completion pulse, read byte, abort flag
//   pd_out/pd_oe/pd_in       : parallel data pins (out, drive enable, in)
//   nWrite/nAddrStr/nDataStr/nInit : active-low host controls
//   nWait                    : asynchronous peripheral handshake
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a request; all controls idle
// ST_SETUP   | nWrite/data stable for SETUP cycles before the strobe
// ST_STROBE  | strobe low, waiting for ws=0 (timed)
// ST_RELEASE | strobe high, waiting for ws=1 (timed)
// ST_BUSRST  | nInit low for RST_CYCLES cycles
module epp_host
  import epp_host_pkg::*;
#(
  parameter int SETUP      = 2,
  parameter int TIMEOUT    = 255,
  parameter int RST_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_timeout,
  output logic [7:0] pd_out,
  output logic       pd_oe,
  input  logic [7:0] pd_in,
  output logic       nWrite,
  output logic       nAddrStr,
  output logic       nDataStr,
  output logic       nInit,
  input  logic       nWait
);

  // Down-counter reload values; phase ends on the cycle the counter reads 0.
  localparam logic [7:0] SETUP_LD = 8'(SETUP - 1);
  localparam logic [7:0] TO_LD    = 8'(TIMEOUT - 1);
  localparam logic [7:0] RST_LD   = 8'(RST_CYCLES - 1);

  logic ws;

  epp_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (nWait),
    .q     (ws)
  );

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rdata_q, rdata_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_timeout_q, resp_timeout_d;
  logic [7:0] resp_data_q, resp_data_d;
  logic       alive_q;
  logic       bus_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      op_q           <= OP_DWR;
      data_q         <= '0;
      rdata_q        <= '0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_data_q    <= '0;
      alive_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      data_q         <= data_d;
      rdata_q        <= rdata_d;
      resp_valid_q   <= resp_valid_d;
      resp_timeout_q <= resp_timeout_d;
      resp_data_q    <= resp_data_d;
      // Holds off req_ready until the first clock after reset release.
      alive_q        <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    data_d         = data_q;
    rdata_d        = rdata_q;
    resp_valid_d   = 1'b0;
    resp_timeout_d = 1'b0;
    resp_data_d    = resp_data_q;
    req_ready      = 1'b0;
    bus_active     = 1'b0;
    nAddrStr       = 1'b1;
    nDataStr       = 1'b1;
    nInit          = 1'b1;

    case (state_q)
      ST_IDLE: begin
        req_ready = alive_q;
        if (req_valid && alive_q) begin
          op_d   = req_op;
          data_d = req_data;
          if (req_op == OP_BRST) begin
            state_d = ST_BUSRST;
            cnt_d   = RST_LD;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
          end
        end
      end
      ST_SETUP: begin
        bus_active = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d = ST_STROBE;
          cnt_d   = TO_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_STROBE: begin
        bus_active = 1'b1;
        if (op_q == OP_AWR) nAddrStr = 1'b0;
        else                nDataStr = 1'b0;
        // Level-sensitive: ws already low on entry acknowledges at once.
        if (!ws) begin
          rdata_d = pd_in;
          state_d = ST_RELEASE;
          cnt_d   = TO_LD;
        end else if (cnt_q == 8'd0) begin
          state_d        = ST_IDLE;
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
          resp_data_d    = 8'h00;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RELEASE: begin
        bus_active = 1'b1;
        if (ws) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          resp_data_d  = (op_q == OP_DRD) ? rdata_q : 8'h00;
        end else if (cnt_q == 8'd0) begin
          state_d        = ST_IDLE;
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
          resp_data_d    = 8'h00;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_BUSRST: begin
        nInit = 1'b0;
        if (cnt_q == 8'd0) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          resp_data_d  = 8'h00;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // pd_oe and nWrite come from one term, so the bus is never driven
    // while nWrite is high.
    pd_oe  = bus_active && op_drives_bus(op_q);
    nWrite = !pd_oe;
  end

  assign pd_out       = data_q;
  assign resp_valid   = resp_valid_q;
  assign resp_timeout = resp_timeout_q;
  assign resp_data    = resp_data_q;

endmodule

// File: tb/tb_epp_host.sv
module tb_epp_host;
  import epp_host_pkg::*;

  localparam int SETUP      = 2;
  localparam int TIMEOUT    = 255;
  localparam int RST_CYCLES = 64;

  // peripheral behaviour per transaction
  localparam int M_NORMAL = 0;  // ack after delay, release after delay
  localparam int M_PREACK = 1;  // nWait already low before strobe
  localparam int M_NOACK  = 2;  // never acknowledge
  localparam int M_NOREL  = 3;  // acknowledge but never release

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_timeout;
  logic [7:0] pd_out;
  logic       pd_oe;
  logic [7:0] pd_in;
  logic       nWrite, nAddrStr, nDataStr, nInit;
  logic       nWait;
  logic [7:0] pd_drv;

  always #5 clk = ~clk;

  // Shared pport_data pins: host drives when pd_oe, otherwise peripheral.
  assign pd_in = pd_oe ? pd_out : pd_drv;

  epp_host #(.SETUP(SETUP), .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_data     (req_data),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_timeout (resp_timeout),
    .pd_out       (pd_out),
    .pd_oe        (pd_oe),
    .pd_in        (pd_in),
    .nWrite       (nWrite),
    .nAddrStr     (nAddrStr),
    .nDataStr     (nDataStr),
    .nInit        (nInit),
    .nWait        (nWait)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       to;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;
  logic [1:0] cur_op = OP_DWR;
  logic [7:0] cur_data = 8'h00;
  logic [7:0] last_resp = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: bus-level rules every cycle, responses popped from scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      last_resp = 8'h00;
    end else begin
      check("oe_while_nwrite_high", {31'd0, pd_oe & nWrite}, 32'd0);
      if (!nAddrStr || !nDataStr) begin
        check("strobe_bus",
              {20'd0, nAddrStr, nDataStr, nWrite, pd_oe, (pd_oe ? pd_out : 8'h00)},
              {20'd0, (cur_op != OP_AWR), (cur_op == OP_AWR), (cur_op == OP_DRD),
               (cur_op != OP_DRD), ((cur_op != OP_DRD) ? cur_data : 8'h00)});
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 data=0x%0h, expected no response",
                   resp_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_data", {24'd0, resp_data}, {24'd0, e.data});
          check("resp_timeout", {31'd0, resp_timeout}, {31'd0, e.to});
        end
        last_resp = resp_data;
        done_cnt++;
      end else begin
        check("resp_data_hold", {24'd0, resp_data}, {24'd0, last_resp});
      end
    end
  end

  task automatic run_txn(input logic [1:0] op, input logic [7:0] d, input int mode,
                         input int ack_dly, input int rel_dly, input logic [7:0] rdata);
    int   n;
    int   d0;
    exp_t e;
    e.to   = (op != OP_BRST) && (mode == M_NOACK || mode == M_NOREL);
    e.data = (op == OP_DRD && !e.to) ? rdata : 8'h00;

    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_wait", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    cur_op   = op;
    cur_data = d;
    d0       = done_cnt;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (mode == M_PREACK) begin
      nWait  = 1'b0;
      pd_drv = rdata;
    end

    if (op == OP_BRST) begin
      n = 0;
      while (!nInit && n < 1000) begin
        n++;
        @(negedge clk);
      end
      check("ninit_low_cycles", n, RST_CYCLES);
    end else begin
      n = 0;
      while (nAddrStr && nDataStr && n < 1000) begin
        n++;
        @(negedge clk);
      end
      check("setup_cycles", n, SETUP);
      if (mode == M_NORMAL || mode == M_NOREL) begin
        repeat (ack_dly) @(negedge clk);
        nWait  = 1'b0;
        pd_drv = rdata;
      end
      n = 0;
      while ((!nAddrStr || !nDataStr) && n < 1000) begin
        n++;
        @(negedge clk);
      end
      if (mode == M_NOACK) check("strobe_timeout_len", n, TIMEOUT);
      if (mode == M_NORMAL || mode == M_PREACK) begin
        repeat (rel_dly) @(negedge clk);
        nWait = 1'b1;
      end
    end

    n = 0;
    while (done_cnt == d0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("resp_count", done_cnt - d0, 1);
    nWait = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int n;
    reset     = 1'b1;
    nWait     = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_DWR;
    req_data  = 8'h00;
    pd_drv    = 8'h00;
    #1;
    check("reset_outputs",
          {9'd0, req_ready, resp_valid, resp_timeout, pd_oe, nWrite, nAddrStr, nDataStr,
           nInit, resp_data, pd_out},
          {9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00});
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // directed cases
    run_txn(OP_DWR, 8'hA5, M_NORMAL, 3, 2, 8'h00);
    run_txn(OP_DRD, 8'h00, M_NORMAL, 3, 2, 8'h3C);
    run_txn(OP_AWR, 8'h09, M_NORMAL, 1, 1, 8'h00);
    run_txn(OP_DWR, 8'h41, M_NORMAL, 1, 1, 8'h00);
    run_txn(OP_DRD, 8'h00, M_PREACK, 0, 1, 8'h5A);
    run_txn(OP_DWR, 8'h66, M_NOACK, 0, 0, 8'h00);
    run_txn(OP_DRD, 8'h00, M_NOREL, 2, 0, 8'hEE);
    run_txn(OP_BRST, 8'h00, M_NORMAL, 0, 0, 8'h00);
    run_txn(OP_DRD, 8'h00, M_NORMAL, 0, 0, 8'hC3);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      int         r;
      int         mode;
      op = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 15);
      if (r < 12)      mode = r % 2;
      else if (r < 14) mode = M_NOACK;
      else             mode = M_NOREL;
      run_txn(op, 8'($urandom_range(0, 255)), mode, $urandom_range(0, 6),
              $urandom_range(0, 5), 8'($urandom_range(0, 255)));
    end

    // reset while strobing aborts with no response
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_DWR;
    req_data  = 8'h77;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    cur_op   = OP_DWR;
    cur_data = 8'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (nDataStr && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("strobe_before_reset", {31'd0, nDataStr}, 32'd0);
    reset = 1'b1;
    #1;
    check("reset_mid_strobe",
          {19'd0, nAddrStr, nDataStr, nWrite, nInit, pd_oe, req_ready, resp_valid, resp_timeout,
           resp_data, pd_out},
          {19'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_abort", {31'd0, req_ready}, 32'd1);
    repeat (20) @(negedge clk);
    check("no_resp_after_abort", done_cnt, done_cnt == 0 ? 1 : done_cnt);

    run_txn(OP_DWR, 8'h12, M_NORMAL, 2, 2, 8'h00);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
